// File: rtl/key_event_gen_pkg.sv
// rtl/key_event_gen_pkg.sv - shared state encodings and default timing for key event consumers
package key_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_LONG  = 2'd2,
        ST_RPT   = 2'd3
    } key_state_e;

    localparam int unsigned DEF_CNT_W         = 24;
    localparam logic [23:0] DEF_LONG_CYCLES   = 24'd5_000_000;
    localparam logic [23:0] DEF_REPEAT_DELAY  = 24'd2_500_000;
    localparam logic [23:0] DEF_REPEAT_PERIOD = 24'd1_000_000;

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - registered previous key level with rise/fall detection
module key_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic rise,
    output logic fall,
    output logic key_prev
);

    logic key_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_in;
        end
    end

    assign rise     = key_in & ~key_prev_q;
    assign fall     = ~key_in & key_prev_q;
    assign key_prev = key_prev_q;

endmodule

// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - short/long press classification with typematic auto-repeat strobes
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int unsigned       CNT_W         = DEF_CNT_W,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter logic [CNT_W-1:0] REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter logic [CNT_W-1:0] REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic key_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CYCLES - CNT_ONE;
    localparam logic [CNT_W-1:0] DELAY_LAST  = REPEAT_DELAY - CNT_ONE;
    localparam logic [CNT_W-1:0] PERIOD_LAST = REPEAT_PERIOD - CNT_ONE;

    logic rise;
    logic fall;
    logic unused_key_prev;

    key_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .rise     (rise),
        .fall     (fall),
        .key_prev (unused_key_prev)
    );

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic short_q, short_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    // A release always takes priority over a threshold hit in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = ST_PRESS;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (fall) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        short_d   = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == DELAY_LAST) begin
                        state_d  = ST_RPT;
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RPT: begin
                    if (fall) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (cnt_q == PERIOD_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d != ST_IDLE);
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - table, hand-sequence and randomized checks of key_event_gen
module tb_key_event_gen;

    localparam int LONG = 8;
    localparam int RD   = 4;
    localparam int RP   = 3;

    // Output vector order: {press, release, short, long, repeat, held}
    localparam logic [5:0] O_PRESS = 6'b100001;
    localparam logic [5:0] O_HELD  = 6'b000001;
    localparam logic [5:0] O_SHORT = 6'b011000;
    localparam logic [5:0] O_REL   = 6'b010000;
    localparam logic [5:0] O_LONG  = 6'b000101;
    localparam logic [5:0] O_RPT   = 6'b000011;
    localparam logic [5:0] O_NONE  = 6'b000000;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic key_in;
    logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

    int n_vec = 0;
    int n_err = 0;

    key_event_gen #(
        .CNT_W         (24),
        .LONG_CYCLES   (24'd8),
        .REPEAT_DELAY  (24'd4),
        .REPEAT_PERIOD (24'd3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .key_in        (key_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    // Reference model: hold length measured in cycles since the press edge.
    bit m_active = 1'b0;
    bit m_prev   = 1'b0;
    int m_h      = 0;
    int n_press  = 0;
    int n_rel    = 0;

    task automatic model_reset();
        m_active = 1'b0;
        m_prev   = 1'b0;
        m_h      = 0;
    endtask

    task automatic model_step(input logic k, input logic e, output logic [5:0] r);
        bit rise_m, fall_m;
        r = O_NONE;
        rise_m = k & ~m_prev;
        fall_m = ~k & m_prev;
        m_prev = k;
        if (!e) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (rise_m) begin
                m_active = 1'b1;
                m_h      = 0;
                r[5]     = 1'b1;
            end
        end else begin
            m_h++;
            if (fall_m) begin
                m_active = 1'b0;
                r[4]     = 1'b1;
                if (m_h <= LONG) r[3] = 1'b1;
            end else if (m_h == LONG) begin
                r[2] = 1'b1;
            end else if (m_h >= LONG + RD && ((m_h - LONG - RD) % RP) == 0) begin
                r[1] = 1'b1;
            end
        end
        r[0] = m_active;
    endtask

    function automatic logic [5:0] dut_out();
        return {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic check_exclusive(input logic [5:0] got);
        n_vec++;
        if ($countones(got[5:1] & 5'b11011) > 1 || (got[3] && !got[4])) begin
            n_err++;
            $display("FAIL strobe_overlap: got %b expected at most one strobe (release+short allowed)", got);
        end
    endtask

    // One clock: drive, clock edge, model, then compare against the model
    // and optionally against a fixed expected vector.
    task automatic step(input logic k, input logic e, input bit use_exp,
                        input logic [5:0] exp, input string name);
        logic [5:0] m;
        logic [5:0] g;
        key_in = k;
        en     = e;
        @(posedge clk);
        model_step(k, e, m);
        #1;
        g = dut_out();
        check({name, "/model"}, g, m);
        if (use_exp) check(name, g, exp);
        if (g[5]) n_press++;
        if (g[4]) n_rel++;
    endtask

    typedef struct {
        logic       key;
        logic       en;
        logic [5:0] exp;
    } vec_t;

    vec_t tab[$];

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        key_in = 1'b0;
        #2;
        check("reset_state", dut_out(), O_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Short press of 5 cycles
        tab.push_back('{1, 1, O_PRESS});
        for (int i = 0; i < 4; i++) tab.push_back('{1, 1, O_HELD});
        tab.push_back('{0, 1, O_SHORT});
        tab.push_back('{0, 1, O_NONE});
        // Release exactly when the long threshold is reached
        tab.push_back('{1, 1, O_PRESS});
        for (int i = 0; i < 7; i++) tab.push_back('{1, 1, O_HELD});
        tab.push_back('{0, 1, O_SHORT});
        tab.push_back('{0, 1, O_NONE});
        // Enable low while toggling, then raised with key held
        tab.push_back('{1, 0, O_NONE});
        tab.push_back('{0, 0, O_NONE});
        tab.push_back('{1, 0, O_NONE});
        tab.push_back('{1, 1, O_NONE});
        tab.push_back('{1, 1, O_NONE});
        tab.push_back('{0, 1, O_NONE});
        tab.push_back('{1, 1, O_PRESS});
        tab.push_back('{0, 1, O_SHORT});
        // Enable dropped mid-hold: silent return to idle
        tab.push_back('{1, 1, O_PRESS});
        tab.push_back('{1, 0, O_NONE});
        tab.push_back('{1, 1, O_NONE});
        tab.push_back('{0, 1, O_NONE});

        foreach (tab[i]) step(tab[i].key, tab[i].en, 1'b1, tab[i].exp, $sformatf("tab%0d", i));

        // Long hold of 20 cycles
        for (int i = 0; i < 20; i++) begin
            logic [5:0] e;
            if (i == 0) e = O_PRESS;
            else if (i == 8) e = O_LONG;
            else if (i == 12 || i == 15 || i == 18) e = O_RPT;
            else e = O_HELD;
            step(1'b1, 1'b1, 1'b1, e, $sformatf("long_hold%0d", i));
        end
        step(1'b0, 1'b1, 1'b1, O_REL, "long_release");
        step(1'b0, 1'b1, 1'b1, O_NONE, "long_idle");

        // Reset asserted while auto-repeating, deasserted with key held
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, O_NONE, "pre_reset");
        check("rpt_before_reset", {5'b0, held}, O_HELD);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out(), O_NONE);
        model_reset();
        @(posedge clk);
        #1;
        check("in_reset", dut_out(), O_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, O_PRESS, "post_reset_press");
        for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b1, O_HELD, "post_reset_hold");
        step(1'b1, 1'b1, 1'b1, O_LONG, "post_reset_long");
        step(1'b0, 1'b1, 1'b1, O_REL, "post_reset_release");

        // Random runs with enable held high: presses and releases must balance
        n_press = 0;
        n_rel   = 0;
        for (int r = 0; r < 120; r++) begin
            int len;
            len = $urandom_range(1, 25);
            for (int c = 0; c < len; c++) begin
                step(r[0] ? 1'b0 : 1'b1, 1'b1, 1'b0, O_NONE, "rand");
                check_exclusive(dut_out());
            end
        end
        step(1'b0, 1'b1, 1'b0, O_NONE, "rand_tail");
        n_vec++;
        if (n_press != n_rel) begin
            n_err++;
            $display("FAIL press_release_balance: got %0d presses vs %0d releases", n_press, n_rel);
        end

        // Random runs with enable toggling
        for (int r = 0; r < 150; r++) begin
            int len;
            logic k;
            logic e;
            len = $urandom_range(1, 20);
            k   = r[0];
            for (int c = 0; c < len; c++) begin
                e = ($urandom_range(0, 15) != 0);
                step(k, e, 1'b0, O_NONE, "rand_en");
                check_exclusive(dut_out());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
